// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: select codes, Funct and Alu_Op codes, FSM states, decode helper.
// ALU_SEQ_MUL_EN enables the iterative multiplier (Funct 0x18); without it 0x18 decodes as illegal.
package alu_pkg;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SRL = 3'b100;
    localparam logic [2:0] SEL_SLL = 3'b101;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_XOR = 3'b111;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    localparam logic [1:0] ALU_OP_ADD     = 2'b00;
    localparam logic [1:0] ALU_OP_SUB     = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE   = 2'b10;
    localparam logic [1:0] ALU_OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
`ifdef ALU_SEQ_MUL_EN
        ST_MUL  = 2'b10,
`endif
        ST_DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic [2:0] sel;
        logic       illegal;
`ifdef ALU_SEQ_MUL_EN
        logic       is_mul;
`endif
    } dec_t;

    function automatic dec_t decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
        dec_t d;
        d.sel     = SEL_ADD;
        d.illegal = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        d.is_mul  = 1'b0;
`endif
        case (alu_op)
            ALU_OP_ADD:     d.sel = SEL_ADD;
            ALU_OP_SUB:     d.sel = SEL_SUB;
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: d.sel = SEL_ADD;
                    FUNCT_SUB: d.sel = SEL_SUB;
                    FUNCT_AND: d.sel = SEL_AND;
                    FUNCT_OR:  d.sel = SEL_OR;
                    FUNCT_XOR: d.sel = SEL_XOR;
                    FUNCT_SLL: d.sel = SEL_SLL;
                    FUNCT_SRL: d.sel = SEL_SRL;
`ifdef ALU_SEQ_MUL_EN
                    FUNCT_MUL: d.is_mul = 1'b1;
`else
                    FUNCT_MUL: d.illegal = 1'b1;
`endif
                    default:   d.illegal = 1'b1;
                endcase
            end
            ALU_OP_ILLEGAL: d.illegal = 1'b1;
            default:        d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between a requester (master) and the ALU sequencer (slave).
interface alu_sequencer_if #(
    parameter int Bus_Width = 16
);
    logic                 In_Valid;
    logic                 In_Ready;
    logic [1:0]           Alu_Op;
    logic [5:0]           Funct;
    logic [Bus_Width-1:0] DataA;
    logic [Bus_Width-1:0] DataB;
    logic                 Out_Valid;
    logic                 Out_Ready;
    logic [Bus_Width-1:0] Result;
    logic                 Zero;
    logic                 Illegal;

    modport master (
        output In_Valid, Alu_Op, Funct, DataA, DataB, Out_Ready,
        input  In_Ready, Out_Valid, Result, Zero, Illegal
    );

    modport slave (
        input  In_Valid, Alu_Op, Funct, DataA, DataB, Out_Ready,
        output In_Ready, Out_Valid, Result, Zero, Illegal
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath selected by the 3-bit operation select.
module alu_core
    import alu_pkg::*;
#(
    parameter int Bus_Width = 16
) (
    input  logic [Bus_Width-1:0] data_a,
    input  logic [Bus_Width-1:0] data_b,
    input  logic [2:0]           sel,
    output logic [Bus_Width-1:0] result
);

    localparam logic [Bus_Width-1:0] SHAMT_LIMIT = Bus_Width'(Bus_Width);

    logic shift_oob;
    assign shift_oob = (data_b >= SHAMT_LIMIT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = '0;
        case (sel)
            SEL_AND: result = data_a & data_b;
            SEL_OR:  result = data_a | data_b;
            SEL_ADD: result = data_a + data_b;
            SEL_SUB: result = data_a - data_b;
            SEL_XOR: result = data_a ^ data_b;
            SEL_SLL: result = shift_oob ? '0 : (data_a << data_b);
            SEL_SRL: result = shift_oob ? '0 : (data_a >> data_b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Handshaked ALU sequencer: accepts one request, executes it, holds the registered result until taken.
// ALU_SEQ_MUL_EN adds an LSB-first shift-add multiplier taking Bus_Width iterations.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int Bus_Width = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);

    state_e state_q, state_d;
    dec_t   dec;
    logic   accept;
    logic   in_ready;
    logic   out_valid;

    logic [Bus_Width-1:0] a_q, b_q;
    logic [2:0]           sel_q;
    logic                 illegal_req_q;
    logic [Bus_Width-1:0] core_y;

    logic [Bus_Width-1:0] result_q;
    logic                 zero_q;
    logic                 illegal_q;

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(Bus_Width + 1);
    localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(Bus_Width);

    logic [Bus_Width-1:0] acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 mul_done;

    assign mul_done = (cnt_q == MUL_ITERS);
`endif

    assign dec = decode_op(bus.Alu_Op, bus.Funct);

    alu_core #(
        .Bus_Width (Bus_Width)
    ) u_core (
        .data_a (a_q),
        .data_b (b_q),
        .sel    (sel_q),
        .result (core_y)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.In_Valid) begin
                    accept = 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    state_d = dec.is_mul ? ST_MUL : ST_EXEC;
`else
                    state_d = ST_EXEC;
`endif
                end
            end
            ST_EXEC: state_d = ST_DONE;
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: if (mul_done) state_d = ST_DONE;
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (bus.Out_Ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are reused as multiplicand/multiplier shift registers during MUL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q           <= '0;
            b_q           <= '0;
            sel_q         <= SEL_ADD;
            illegal_req_q <= 1'b0;
            result_q      <= '0;
            zero_q        <= 1'b0;
            illegal_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q         <= '0;
            cnt_q         <= '0;
`endif
        end else begin
            if (accept) begin
                a_q           <= bus.DataA;
                b_q           <= bus.DataB;
                sel_q         <= dec.sel;
                illegal_req_q <= dec.illegal;
`ifdef ALU_SEQ_MUL_EN
                acc_q         <= '0;
                cnt_q         <= '0;
`endif
            end

            if (state_q == ST_EXEC) begin
                result_q  <= illegal_req_q ? '0 : core_y;
                zero_q    <= illegal_req_q || (core_y == '0);
                illegal_q <= illegal_req_q;
            end

`ifdef ALU_SEQ_MUL_EN
            if (state_q == ST_MUL) begin
                if (mul_done) begin
                    result_q  <= acc_q;
                    zero_q    <= (acc_q == '0);
                    illegal_q <= 1'b0;
                end else begin
                    if (b_q[0]) acc_q <= acc_q + a_q;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
`endif
        end
    end

    assign bus.In_Ready  = in_ready;
    assign bus.Out_Valid = out_valid;
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus randomized requests against a reference model.
module tb_alu_sequencer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_sequencer_if #(.Bus_Width(W)) bus ();

    alu_sequencer #(.Bus_Width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the operation table, using plain arithmetic.
    function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ill, output int lat);
        r   = '0;
        ill = 1'b0;
        lat = 1;
        case (op)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: begin
                case (f)
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h26: r = a ^ b;
                    6'h00: r = (int'(b) >= W) ? '0 : a << b;
                    6'h02: r = (int'(b) >= W) ? '0 : a >> b;
`ifdef ALU_SEQ_MUL_EN
                    6'h18: begin r = a * b; lat = W + 1; end
`else
                    6'h18: ill = 1'b1;
`endif
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Entered and left idle, #1 after a rising edge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input logic ready_early);
        logic [W-1:0] er;
        logic         ei;
        int           el;
        int           lat;
        model(op, f, a, b, er, ei, el);
        check({tag, "_in_ready"}, 32'(bus.In_Ready), 32'd1);
        bus.In_Valid  = 1'b1;
        bus.Alu_Op    = op;
        bus.Funct     = f;
        bus.DataA     = a;
        bus.DataB     = b;
        bus.Out_Ready = ready_early;
        @(posedge clk); #1;
        bus.In_Valid = 1'b0;
        bus.Alu_Op   = 2'($urandom);
        bus.Funct    = 6'($urandom);
        bus.DataA    = 16'($urandom);
        bus.DataB    = 16'($urandom);
        lat = 0;
        while (!bus.Out_Valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(el));
        check({tag, "_result"}, 32'(bus.Result), 32'(er));
        check({tag, "_zero"}, 32'(bus.Zero), 32'(er == '0));
        check({tag, "_illegal"}, 32'(bus.Illegal), 32'(ei));
        if (!ready_early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, 32'(bus.Out_Valid), 32'd1);
                check({tag, "_hold_result"}, 32'(bus.Result), 32'(er));
            end
            bus.Out_Ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.Out_Ready = 1'b0;
        check({tag, "_released"}, 32'(bus.Out_Valid), 32'd0);
        check({tag, "_back_idle"}, 32'(bus.In_Ready), 32'd1);
    endtask

    // Called #1 after an edge; asserts reset, releases it and watches for stray responses.
    task automatic reset_check(input string tag);
        int stray;
        rst = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 32'(bus.Out_Valid), 32'd0);
        check({tag, "_rst_result"}, 32'(bus.Result), 32'd0);
        check({tag, "_rst_zero"}, 32'(bus.Zero), 32'd0);
        check({tag, "_rst_illegal"}, 32'(bus.Illegal), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.In_Valid = 1'b0;
        #1;
        check({tag, "_post_in_ready"}, 32'(bus.In_Ready), 32'd1);
        check({tag, "_post_valid"}, 32'(bus.Out_Valid), 32'd0);
        check({tag, "_post_result"}, 32'(bus.Result), 32'd0);
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.Out_Valid) stray++;
        end
        check({tag, "_no_response"}, 32'(stray), 32'd0);
    endtask

    initial begin
        logic [1:0] rop;
        logic [5:0] rf;
        logic [W-1:0] ra, rb;

        rst           = 1'b1;
        bus.In_Valid  = 1'b0;
        bus.Alu_Op    = 2'd0;
        bus.Funct     = 6'd0;
        bus.DataA     = '0;
        bus.DataB     = '0;
        bus.Out_Ready = 1'b0;
        #2;
        check("reset_valid", 32'(bus.Out_Valid), 32'd0);
        check("reset_result", 32'(bus.Result), 32'd0);
        check("reset_zero", 32'(bus.Zero), 32'd0);
        check("reset_illegal", 32'(bus.Illegal), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("reset_release_ready", 32'(bus.In_Ready), 32'd1);

        run_op("add", 2'b00, 6'h00, 16'h0003, 16'h0004, 0, 1'b0);
        check("add_const", 32'(bus.Result), 32'h0007);
        run_op("sub", 2'b01, 6'h00, 16'h1234, 16'h1234, 1, 1'b0);
        check("sub_zero_const", 32'(bus.Zero), 32'd1);
        run_op("sll16", 2'b10, 6'h00, 16'h0001, 16'h0010, 0, 1'b1);
        check("sll16_const", 32'(bus.Result), 32'h0000);
        run_op("srl15", 2'b10, 6'h02, 16'h8000, 16'd15, 0, 1'b0);
        check("srl15_const", 32'(bus.Result), 32'h0001);
        run_op("illegal3f", 2'b10, 6'h3F, 16'h5555, 16'h00AA, 0, 1'b0);
        check("illegal3f_flag", 32'(bus.Illegal), 32'd1);
        run_op("aluop11", 2'b11, 6'h20, 16'h0101, 16'h0202, 0, 1'b1);
        run_op("mul_code", 2'b10, 6'h18, 16'h0012, 16'h0034, 2, 1'b0);
`ifdef ALU_SEQ_MUL_EN
        check("mul_const", 32'(bus.Result), 32'h03A8);

        // Abandon a multiply after five iterations.
        bus.In_Valid = 1'b1;
        bus.Alu_Op   = 2'b10;
        bus.Funct    = 6'h18;
        bus.DataA    = 16'h0003;
        bus.DataB    = 16'h0005;
        @(posedge clk); #1;
        bus.In_Valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_check("mid_mul");
`else
        check("mul_disabled_illegal", 32'(bus.Illegal), 32'd1);
`endif

        // Backpressure: result parked in DONE while a second request waits on In_Valid.
        bus.In_Valid  = 1'b1;
        bus.Alu_Op    = 2'b10;
        bus.Funct     = 6'h25;
        bus.DataA     = 16'h00F0;
        bus.DataB     = 16'h0F00;
        bus.Out_Ready = 1'b0;
        @(posedge clk); #1;
        bus.Alu_Op = 2'b00;
        bus.DataA  = 16'h0001;
        bus.DataB  = 16'h0001;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(bus.Out_Valid), 32'd1);
            check("bp_result", 32'(bus.Result), 32'h0FF0);
            check("bp_in_ready", 32'(bus.In_Ready), 32'd0);
            @(posedge clk); #1;
        end
        check("bp_still_result", 32'(bus.Result), 32'h0FF0);
        bus.Out_Ready = 1'b1;
        @(posedge clk); #1;
        bus.Out_Ready = 1'b0;
        check("bp_exit_valid", 32'(bus.Out_Valid), 32'd0);
        check("bp_exit_ready", 32'(bus.In_Ready), 32'd1);
        check("bp_no_early_accept", 32'(bus.Result), 32'h0FF0);
        @(posedge clk); #1;
        bus.In_Valid = 1'b0;
        @(posedge clk); #1;
        check("bp_second_valid", 32'(bus.Out_Valid), 32'd1);
        check("bp_second_result", 32'(bus.Result), 32'h0002);

        // Reset while a response sits in DONE.
        reset_check("in_done");

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: rf = 6'h20;
                1: rf = 6'h22;
                2: rf = 6'h24;
                3: rf = 6'h25;
                4: rf = 6'h26;
                5: rf = 6'h00;
                6: rf = 6'h02;
                7: rf = 6'h18;
                default: rf = 6'($urandom);
            endcase
            if (rop == 2'b11 && n % 2 == 0) rop = 2'b10;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op("rand", rop, rf, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter Bus_Width, default 16, which sets the operand and result width and must be at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports In_Valid (input, 1) and In_Ready (output, 1): the request handshake; a transfer occurs on a clk edge when both are high.
REQ-005 SHALL have port Alu_Op, input, 2 bits: 00 = ADD, 01 = SUB, 10 = decode from Funct, 11 = illegal.
REQ-006 SHALL have port Funct, input, 6 bits: the R-type function field.
REQ-007 SHALL have ports DataA and DataB, input, Bus_Width bits each: the operands.
REQ-008 SHALL have ports Out_Valid (output, 1) and Out_Ready (input, 1): the response handshake.
REQ-009 SHALL have port Result, output, Bus_Width bits: the registered result.
REQ-010 SHALL have ports Zero (output, 1, registered, high when the latched Result is 0) and Illegal (output, 1, registered).

Function
REQ-011 SHALL capture Alu_Op, Funct, DataA and DataB on the accept edge, and inputs SHALL be ignored when In_Ready is low.
REQ-012 SHALL decode Funct as follows: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x00 SLL, 0x02 SRL, 0x18 MUL; any other value is illegal.
REQ-013 SHALL map decoded ops to the 3-bit select: AND 000, OR 001, ADD 010, SRL 100, SLL 101, SUB 110, XOR 111.
REQ-014 SHALL implement the FSM states IDLE, EXEC, MUL and DONE; reset state is IDLE; In_Ready is high only in IDLE.
REQ-015 SHALL make these FSM transitions:
- IDLE -> EXEC on accept of a non-MUL request.
- IDLE -> MUL on accept of a MUL request.
- EXEC -> DONE after one cycle.
- MUL -> DONE after Bus_Width iterations.
- DONE -> IDLE on a clk edge with Out_Ready high.
REQ-016 SHALL, for a single-cycle op accepted at edge N, assert Out_Valid after edge N+1.
REQ-017 SHALL, for MUL accepted at edge N, assert Out_Valid after edge N+Bus_Width+1.
REQ-018 SHALL perform ADD and SUB modulo 2^Bus_Width with the carry discarded.
REQ-019 SHALL use the full DataB value as the shift amount for SLL and SRL, and a shift amount of Bus_Width or more SHALL yield 0.
REQ-020 SHALL compute MUL as iterative shift-add, one multiplier bit per cycle, LSB first, with Result equal to the low Bus_Width bits of the product.
REQ-021 SHALL handle an illegal request in one cycle with Result = 0, Zero = 1 and Illegal = 1; Illegal SHALL be 0 for every legal op.
REQ-022 SHALL hold Result, Zero and Illegal stable while Out_Valid is high and Out_Ready is low.
REQ-023 SHALL return to IDLE when Out_Ready is already high on the first Out_Valid cycle, in which case Out_Valid is high for exactly one cycle.

Reset
REQ-024 SHALL, while rst is high, immediately force state = IDLE, Out_Valid = 0, Result = 0, Zero = 0 and Illegal = 0, and clear all MUL iteration state.
REQ-025 SHALL abandon any in-flight EXEC, MUL or DONE operation on reset, and SHALL produce no response for it after rst deasserts.
REQ-026 SHALL assert In_Ready in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL support macro ALU_SEQ_MUL_EN:
- Defined: Funct 0x18 executes MUL per REQ-017 and REQ-020.
- Undefined: Funct 0x18 is illegal per REQ-021, and the MUL state and multiplier datapath are absent.

Structure
REQ-028 SHALL place the 3-bit select localparams, the Funct codes, the Alu_Op codes and the FSM state encoding in a shared package, alu_pkg.
REQ-029 SHALL instantiate one combinational sub-module, alu_core, which takes DataA, DataB and the 3-bit select and produces the result; the sequencer registers its output.

Verification (Bus_Width = 16)
REQ-030 SHALL cover ADD: Alu_Op = 00, A = 0x0003, B = 0x0004 -> Out_Valid one cycle after accept, Result = 0x0007, Zero = 0.
REQ-031 SHALL cover SUB: Alu_Op = 01, A = B = 0x1234 -> Result = 0x0000, Zero = 1, Illegal = 0.
REQ-032 SHALL cover shifts:
- Funct 0x00, A = 0x0001, B = 0x0010 -> Result = 0x0000.
- Funct 0x02, A = 0x8000, B = 15 -> Result = 0x0001.
REQ-033 SHALL cover MUL with the macro defined: A = 0x0012, B = 0x0034 -> Result = 0x03A8, Out_Valid 17 cycles after accept.
REQ-034 SHALL cover backpressure: Out_Ready held low for 3 cycles with In_Valid held high -> Result stable, In_Ready = 0, no second accept until DONE exits.
REQ-035 SHALL cover reset mid-MUL at iteration 5 -> Out_Valid = 0, Result = 0 and In_Ready = 1 in the first cycle after release; an illegal Funct 0x3F -> Illegal = 1, Result = 0.
